x_phaser_tap_bank: RTL and testbench
====================================

Name: x_phaser_tap_bank

Overview:
Multi-channel, multi-rank fine-delay tap controller for the PHASER_IN/OUT family. It holds one TAP_W-bit fine-delay count per (rank, channel) and supports load, inc/dec step and read-back through the COUNTERLOADEN/COUNTERREADEN/FINEENABLE interface. It drives the active rank's taps to the delay lines. After every change to an active tap, and after a rank switch, it enforces a settle window. Sits between the calibration sequencer (SYSCLK domain) and the per-byte delay lines.

Parameters:
NUM_CH, 4, number of delay channels (1..16)
NUM_RANKS, 4, number of stored rank settings (1..4)
TAP_W, 6, tap counter width (max tap = 2^TAP_W-1)
FINE_DELAY, 0, reset tap value for every entry (0..2^TAP_W-1)
WRAP_MODE, "FALSE", "FALSE" = saturate at 0/max; "TRUE" = modulo wrap
SETTLE_CYCLES, 8, busy cycles after an active-tap change or rank switch (0 = no settle)

Ports:
SYSCLK  in  1  sole clock, all logic on rising edge
RST  in  1  synchronous, active-high reset
CHSEL  in  max(1,clog2(NUM_CH))  channel addressed by command
RANKSEL  in  2  rank addressed by command / target of switch
FINEENABLE  in  1  step addressed tap by one
FINEINC  in  1  step direction: 1 = +1, 0 = -1
COUNTERLOADEN  in  1  load COUNTERLOADVAL into addressed tap
COUNTERLOADVAL  in  TAP_W  load value
COUNTERREADEN  in  1  read addressed tap
RANKSWITCH  in  1  make RANKSEL the active rank
COUNTERREADVAL  out  TAP_W  read data
READVALID  out  1  one-cycle strobe qualifying COUNTERREADVAL
FINEOVERFLOW  out  1  step hit a boundary
CMDERR  out  1  one-cycle strobe: command rejected
BUSY  out  1  settle window active
ACTIVERANK  out  2  current active rank
TAPOUT  out  NUM_CH*TAP_W  active-rank taps, ch0 in LSBs

Behaviour:
- Reset, sampled on the SYSCLK edge: all entries = FINE_DELAY, ACTIVERANK=0, TAPOUT = FINE_DELAY replicated, COUNTERREADVAL=0, READVALID=0, FINEOVERFLOW=0, CMDERR=0, BUSY=0, FSM=IDLE, settle counter=0. RST mid-settle aborts the window immediately.
- Modify commands are load, step and switch.
  - Priority in the same cycle: RANKSWITCH > COUNTERLOADEN > FINEENABLE. Lower-priority modify commands in that cycle are dropped silently.
  - Accepted only when BUSY=0.
  - If BUSY=1, or CHSEL>=NUM_CH, or RANKSEL>=NUM_RANKS: no state change and CMDERR=1 the next cycle.
- Load: entry[RANKSEL][CHSEL] <= COUNTERLOADVAL. Clears FINEOVERFLOW.
- Step, saturate mode: inc at max or dec at 0 leaves the entry unchanged and sets FINEOVERFLOW.
- Step, wrap mode: max+1 -> 0 and 0-1 -> max, and sets FINEOVERFLOW.
- Step with no boundary hit: clears FINEOVERFLOW. FINEOVERFLOW is registered and holds until the next accepted load or step.
- Any update is visible on TAPOUT the cycle after the command, only if RANKSEL==ACTIVERANK. Updates to a non-active rank change storage only and do not start settle.
- RANKSWITCH: ACTIVERANK <= RANKSEL, and TAPOUT reloads from that rank the next cycle. Switching to the already-active rank still starts settle.
- Read:
  - Allowed at any time, including while BUSY; not blocked by a modify command.
  - COUNTERREADVAL = entry value before any same-cycle update. It is valid on the next cycle with READVALID=1 for one cycle.
  - COUNTERREADVAL holds until the next read.
  - An invalid CHSEL/RANKSEL on a read gives CMDERR and no READVALID.
- FSM states IDLE and SETTLE:
  - IDLE->SETTLE on an accepted active-rank load or step, or any accepted switch, when SETTLE_CYCLES>0. The counter loads SETTLE_CYCLES-1.
  - BUSY=1 exactly SETTLE_CYCLES cycles, starting the cycle after the command.
  - SETTLE->IDLE when the counter hits 0.
  - SETTLE_CYCLES=0: the FSM never leaves IDLE.
- Latency: every output is registered, 1 cycle after the command edge.

Decomposition:
- Shared package phaser_pkg: tap-width/max-tap constants, rank-index width, a cmd_e enum (NONE, LOAD, STEP, SWITCH), and a clog2 function.
- One sub-module x_phaser_tap_step: combinational next-tap and overflow for a given value, direction and WRAP_MODE. Reused by the future PHASER_OUT successor.
- Storage, priority, FSM and read path stay in the top level.

Test Plan:
- Reset with FINE_DELAY=5, NUM_CH=4 -> every TAPOUT field 5, ACTIVERANK=0, all flags 0. Read (rank2, ch3) -> READVALID next cycle, COUNTERREADVAL=5.
- Load 62 into (rank0, ch1), wait settle, then two inc steps in saturate mode -> TAPOUT ch1 = 63, then 63 with FINEOVERFLOW=1. BUSY is high for 8 cycles after each change, and only the second step sees overflow.
- WRAP_MODE="TRUE": load 0, then step dec -> tap 63, FINEOVERFLOW=1. Next step inc -> 0, FINEOVERFLOW=1. Then load 10 -> FINEOVERFLOW=0.
- Load 20 into (rank1, ch0) while active rank=0 -> TAPOUT unchanged, BUSY stays 0. RANKSWITCH with RANKSEL=1 -> ACTIVERANK=1, TAPOUT ch0=20, BUSY for 8 cycles.
- Step issued during BUSY -> CMDERR pulse, tap unchanged. Read issued during BUSY -> READVALID and the correct value.
- Load, step and switch asserted together; then RST asserted mid-settle -> only the switch takes effect; reset forces BUSY=0 and all taps=FINE_DELAY next cycle.

Source files
------------

// File: rtl/phaser_pkg.sv
// Shared constants, command encoding and helpers for the PHASER fine-delay tap family.
package phaser_pkg;
  localparam int TAP_W_DEF = 6;
  localparam int RANK_W    = 2;

  typedef enum logic [1:0] {CMD_NONE, CMD_LOAD, CMD_STEP, CMD_SWITCH} cmd_e;
  typedef enum logic {ST_IDLE, ST_SETTLE} state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int max_tap(input int w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/x_phaser_tap_bank_if.sv
// Command/response bundle between the calibration sequencer and the tap bank.
interface x_phaser_tap_bank_if #(
  parameter int NUM_CH = 4,
  parameter int TAP_W  = 6
);
  import phaser_pkg::*;
  localparam int CH_W = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH);

  logic [CH_W-1:0]         CHSEL;
  logic [RANK_W-1:0]       RANKSEL;
  logic                    FINEENABLE;
  logic                    FINEINC;
  logic                    COUNTERLOADEN;
  logic [TAP_W-1:0]        COUNTERLOADVAL;
  logic                    COUNTERREADEN;
  logic                    RANKSWITCH;
  logic [TAP_W-1:0]        COUNTERREADVAL;
  logic                    READVALID;
  logic                    FINEOVERFLOW;
  logic                    CMDERR;
  logic                    BUSY;
  logic [RANK_W-1:0]       ACTIVERANK;
  logic [NUM_CH*TAP_W-1:0] TAPOUT;

  modport master (
    output CHSEL, RANKSEL, FINEENABLE, FINEINC, COUNTERLOADEN, COUNTERLOADVAL,
           COUNTERREADEN, RANKSWITCH,
    input  COUNTERREADVAL, READVALID, FINEOVERFLOW, CMDERR, BUSY, ACTIVERANK, TAPOUT
  );

  modport slave (
    input  CHSEL, RANKSEL, FINEENABLE, FINEINC, COUNTERLOADEN, COUNTERLOADVAL,
           COUNTERREADEN, RANKSWITCH,
    output COUNTERREADVAL, READVALID, FINEOVERFLOW, CMDERR, BUSY, ACTIVERANK, TAPOUT
  );
endinterface

// File: rtl/x_phaser_tap_step.sv
// Combinational +/-1 tap step with boundary detection; saturates or wraps per WRAP_MODE.
module x_phaser_tap_step
  import phaser_pkg::*;
#(
  parameter int    TAP_W     = TAP_W_DEF,
  parameter string WRAP_MODE = "FALSE"
) (
  input  logic [TAP_W-1:0] cur,
  input  logic             inc,
  output logic [TAP_W-1:0] nxt,
  output logic             ovf
);
  localparam logic [TAP_W-1:0] MAX_TAP = TAP_W'(max_tap(TAP_W));
  localparam bit               WRAP    = (WRAP_MODE == "TRUE");

  // MSB of the result is the boundary-hit flag, the rest is the new tap.
  function automatic logic [TAP_W:0] next_tap(input logic [TAP_W-1:0] v, input logic up);
    logic             hit;
    logic [TAP_W-1:0] nv;
    hit = up ? (v == MAX_TAP) : (v == '0);
    nv  = up ? v + 1'b1 : v - 1'b1;
    if (hit && !WRAP) nv = v;
    return {hit, nv};
  endfunction

  assign {ovf, nxt} = next_tap(cur, inc);
endmodule

// File: rtl/x_phaser_tap_bank.sv
// Per-(rank, channel) fine-delay tap storage with load/step/read, rank switching
// and a settle window after any change that reaches the delay lines.
module x_phaser_tap_bank
  import phaser_pkg::*;
#(
  parameter int    NUM_CH        = 4,
  parameter int    NUM_RANKS     = 4,
  parameter int    TAP_W         = TAP_W_DEF,
  parameter int    FINE_DELAY    = 0,
  parameter string WRAP_MODE     = "FALSE",
  parameter int    SETTLE_CYCLES = 8
) (
  input logic                SYSCLK,
  input logic                RST,
  x_phaser_tap_bank_if.slave bus
);
  localparam int CNT_W = (clog2(SETTLE_CYCLES + 1) < 1) ? 1 : clog2(SETTLE_CYCLES + 1);
  localparam logic [TAP_W-1:0] RST_TAP   = TAP_W'(FINE_DELAY);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  logic [TAP_W-1:0]        taps_p1 [NUM_RANKS][NUM_CH];
  logic [NUM_CH*TAP_W-1:0] tapout_p1;
  logic [RANK_W-1:0]       active_p1;
  logic [TAP_W-1:0]        rdval_p1;
  logic                    vld_p1;
  logic                    ovf_p1;
  logic                    err_p1;
  state_e                  state_p1, state_nxt;
  logic [CNT_W-1:0]        cnt_p1, cnt_nxt;

  cmd_e             cmd;
  logic             ch_ok, rank_ok, addr_ok, busy, acc, on_active, rd_ok, cmd_err;
  logic [TAP_W-1:0] cur_tap, step_tap, wr_tap;
  logic             step_ovf;

  x_phaser_tap_step #(.TAP_W(TAP_W), .WRAP_MODE(WRAP_MODE)) u_step (
    .cur (cur_tap),
    .inc (bus.FINEINC),
    .nxt (step_tap),
    .ovf (step_ovf)
  );

  // Stage p0: decode, priority and acceptance of this cycle's command
  always_comb begin
    ch_ok   = (int'(bus.CHSEL) < NUM_CH);
    rank_ok = (int'(bus.RANKSEL) < NUM_RANKS);
    cur_tap = (ch_ok && rank_ok) ? taps_p1[bus.RANKSEL][bus.CHSEL] : '0;
    busy    = (state_p1 == ST_SETTLE);

    cmd = CMD_NONE;
    if (bus.RANKSWITCH)         cmd = CMD_SWITCH;
    else if (bus.COUNTERLOADEN) cmd = CMD_LOAD;
    else if (bus.FINEENABLE)    cmd = CMD_STEP;

    // A switch only needs a valid rank; tap edits need a valid entry.
    addr_ok   = (cmd == CMD_SWITCH) ? rank_ok : (ch_ok && rank_ok);
    acc       = (cmd != CMD_NONE) && !busy && addr_ok;
    on_active = acc && ((cmd == CMD_SWITCH) || (bus.RANKSEL == active_p1));
    rd_ok     = bus.COUNTERREADEN && ch_ok && rank_ok;
    cmd_err   = ((cmd != CMD_NONE) && (busy || !addr_ok)) ||
                (bus.COUNTERREADEN && !(ch_ok && rank_ok));
    wr_tap    = (cmd == CMD_LOAD) ? bus.COUNTERLOADVAL : step_tap;
  end

  always_comb begin
    state_nxt = state_p1;
    cnt_nxt   = cnt_p1;
    case (state_p1)
      ST_IDLE: begin
        if (on_active && (SETTLE_CYCLES > 0)) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = SETTLE_LD;
        end
      end
      ST_SETTLE: begin
        if (cnt_p1 == '0) state_nxt = ST_IDLE;
        else              cnt_nxt   = cnt_p1 - 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stage p1: storage, delay-line image, read data and status registers
  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      for (int r = 0; r < NUM_RANKS; r++)
        for (int c = 0; c < NUM_CH; c++)
          taps_p1[r][c] <= RST_TAP;
      tapout_p1 <= {NUM_CH{RST_TAP}};
      active_p1 <= '0;
      rdval_p1  <= '0;
      vld_p1    <= 1'b0;
      ovf_p1    <= 1'b0;
      err_p1    <= 1'b0;
      state_p1  <= ST_IDLE;
      cnt_p1    <= '0;
    end else begin
      state_p1 <= state_nxt;
      cnt_p1   <= cnt_nxt;
      vld_p1   <= rd_ok;
      err_p1   <= cmd_err;
      if (rd_ok) rdval_p1 <= cur_tap;
      if (acc) begin
        case (cmd)
          CMD_LOAD, CMD_STEP: begin
            taps_p1[bus.RANKSEL][bus.CHSEL] <= wr_tap;
            ovf_p1 <= (cmd == CMD_STEP) && step_ovf;
            if (on_active) tapout_p1[bus.CHSEL*TAP_W +: TAP_W] <= wr_tap;
          end
          CMD_SWITCH: begin
            active_p1 <= bus.RANKSEL;
            for (int c = 0; c < NUM_CH; c++)
              tapout_p1[c*TAP_W +: TAP_W] <= taps_p1[bus.RANKSEL][c];
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.COUNTERREADVAL = rdval_p1;
  assign bus.READVALID      = vld_p1;
  assign bus.FINEOVERFLOW   = ovf_p1;
  assign bus.CMDERR         = err_p1;
  assign bus.BUSY           = (state_p1 == ST_SETTLE);
  assign bus.ACTIVERANK     = active_p1;
  assign bus.TAPOUT         = tapout_p1;
endmodule

// File: tb/tb_x_phaser_tap_bank.sv
// Bench for x_phaser_tap_bank: saturating and wrapping instances, read data scoreboarded.
module tb_x_phaser_tap_bank;
  logic SYSCLK = 1'b0;
  logic RST    = 1'b1;
  always #5 SYSCLK = ~SYSCLK;

  x_phaser_tap_bank_if #(.NUM_CH(4), .TAP_W(6)) bs ();
  x_phaser_tap_bank_if #(.NUM_CH(4), .TAP_W(6)) bw ();

  x_phaser_tap_bank #(.NUM_CH(4), .NUM_RANKS(4), .TAP_W(6), .FINE_DELAY(5),
                      .WRAP_MODE("FALSE"), .SETTLE_CYCLES(8))
    dut_s (.SYSCLK(SYSCLK), .RST(RST), .bus(bs));

  x_phaser_tap_bank #(.NUM_CH(4), .NUM_RANKS(4), .TAP_W(6), .FINE_DELAY(5),
                      .WRAP_MODE("TRUE"), .SETTLE_CYCLES(8))
    dut_w (.SYSCLK(SYSCLK), .RST(RST), .bus(bw));

  int         checks = 0;
  int         passes = 0;
  logic [5:0] rd_q[$];
  logic [5:0] rd_exp;

  // Read-data scoreboard: every READVALID must match the oldest pending expectation.
  always @(negedge SYSCLK) begin
    if (!RST && bs.READVALID === 1'b1) begin
      checks++;
      if (rd_q.size() == 0)
        $display("FAIL rd_unexpected got READVALID with %0d want no read pending", bs.COUNTERREADVAL);
      else begin
        rd_exp = rd_q.pop_front();
        if (bs.COUNTERREADVAL !== rd_exp)
          $display("FAIL rd_data got %0d want %0d", bs.COUNTERREADVAL, rd_exp);
        else passes++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want summary");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic cmd_s(input logic sw, input logic ld, input logic fe, input logic inc,
                       input logic rd, input logic [1:0] rk, input logic [1:0] ch,
                       input logic [5:0] val);
    bs.RANKSWITCH = sw; bs.COUNTERLOADEN = ld; bs.FINEENABLE = fe; bs.FINEINC = inc;
    bs.COUNTERREADEN = rd; bs.RANKSEL = rk; bs.CHSEL = ch; bs.COUNTERLOADVAL = val;
    tick();
    bs.RANKSWITCH = 1'b0; bs.COUNTERLOADEN = 1'b0; bs.FINEENABLE = 1'b0; bs.COUNTERREADEN = 1'b0;
  endtask

  task automatic cmd_w(input logic ld, input logic fe, input logic inc,
                       input logic [1:0] ch, input logic [5:0] val);
    bw.RANKSWITCH = 1'b0; bw.COUNTERLOADEN = ld; bw.FINEENABLE = fe; bw.FINEINC = inc;
    bw.COUNTERREADEN = 1'b0; bw.RANKSEL = 2'd0; bw.CHSEL = ch; bw.COUNTERLOADVAL = val;
    tick();
    bw.COUNTERLOADEN = 1'b0; bw.FINEENABLE = 1'b0;
  endtask

  task automatic settle_s(output int n);
    n = 0;
    while (bs.BUSY === 1'b1 && n < 40) begin n++; tick(); end
  endtask

  task automatic settle_w(output int n);
    n = 0;
    while (bw.BUSY === 1'b1 && n < 40) begin n++; tick(); end
  endtask

  task automatic test_reset();
    RST = 1'b1; tick(); tick(); RST = 1'b0;
    checks++; if (bs.TAPOUT !== {4{6'd5}}) $display("FAIL reset_tapout got %h want %h", bs.TAPOUT, {4{6'd5}}); else passes++;
    checks++; if (bw.TAPOUT !== {4{6'd5}}) $display("FAIL reset_tapout_w got %h want %h", bw.TAPOUT, {4{6'd5}}); else passes++;
    checks++; if (bs.ACTIVERANK !== 2'd0) $display("FAIL reset_rank got %0d want 0", bs.ACTIVERANK); else passes++;
    checks++; if ({bs.BUSY, bs.FINEOVERFLOW, bs.CMDERR, bs.READVALID} !== 4'b0)
      $display("FAIL reset_flags got %b want 0000", {bs.BUSY, bs.FINEOVERFLOW, bs.CMDERR, bs.READVALID}); else passes++;
    checks++; if (bs.COUNTERREADVAL !== 6'd0) $display("FAIL reset_rdval got %0d want 0", bs.COUNTERREADVAL); else passes++;
    rd_q.push_back(6'd5);
    cmd_s(0, 0, 0, 0, 1, 2'd2, 2'd3, 6'd0);
    checks++; if (bs.READVALID !== 1'b1) $display("FAIL rd_valid got %b want 1", bs.READVALID); else passes++;
    tick();
    checks++; if (bs.READVALID !== 1'b0) $display("FAIL rd_pulse got %b want 0", bs.READVALID); else passes++;
    checks++; if (bs.COUNTERREADVAL !== 6'd5) $display("FAIL rd_hold got %0d want 5", bs.COUNTERREADVAL); else passes++;
  endtask

  task automatic test_saturate();
    int n;
    cmd_s(0, 1, 0, 0, 0, 2'd0, 2'd1, 6'd62);
    checks++; if (bs.TAPOUT[11:6] !== 6'd62) $display("FAIL sat_load got %0d want 62", bs.TAPOUT[11:6]); else passes++;
    checks++; if (bs.BUSY !== 1'b1) $display("FAIL sat_busy got %b want 1", bs.BUSY); else passes++;
    settle_s(n);
    checks++; if (n != 8) $display("FAIL sat_settle1 got %0d want 8", n); else passes++;
    cmd_s(0, 0, 1, 1, 0, 2'd0, 2'd1, 6'd0);
    checks++; if (bs.TAPOUT[11:6] !== 6'd63) $display("FAIL sat_inc1 got %0d want 63", bs.TAPOUT[11:6]); else passes++;
    checks++; if (bs.FINEOVERFLOW !== 1'b0) $display("FAIL sat_ovf1 got %b want 0", bs.FINEOVERFLOW); else passes++;
    settle_s(n);
    checks++; if (n != 8) $display("FAIL sat_settle2 got %0d want 8", n); else passes++;
    cmd_s(0, 0, 1, 1, 0, 2'd0, 2'd1, 6'd0);
    checks++; if (bs.TAPOUT[11:6] !== 6'd63) $display("FAIL sat_inc2 got %0d want 63", bs.TAPOUT[11:6]); else passes++;
    checks++; if (bs.FINEOVERFLOW !== 1'b1) $display("FAIL sat_ovf2 got %b want 1", bs.FINEOVERFLOW); else passes++;
    settle_s(n);
    checks++; if (n != 8) $display("FAIL sat_settle3 got %0d want 8", n); else passes++;
    checks++; if (bs.FINEOVERFLOW !== 1'b1) $display("FAIL sat_ovf_hold got %b want 1", bs.FINEOVERFLOW); else passes++;
  endtask

  task automatic test_wrap();
    int n;
    cmd_w(1, 0, 0, 2'd0, 6'd0);
    checks++; if (bw.TAPOUT[5:0] !== 6'd0) $display("FAIL wrap_load0 got %0d want 0", bw.TAPOUT[5:0]); else passes++;
    settle_w(n);
    cmd_w(0, 1, 0, 2'd0, 6'd0);
    checks++; if (bw.TAPOUT[5:0] !== 6'd63) $display("FAIL wrap_dec got %0d want 63", bw.TAPOUT[5:0]); else passes++;
    checks++; if (bw.FINEOVERFLOW !== 1'b1) $display("FAIL wrap_dec_ovf got %b want 1", bw.FINEOVERFLOW); else passes++;
    settle_w(n);
    checks++; if (n != 8) $display("FAIL wrap_settle got %0d want 8", n); else passes++;
    cmd_w(0, 1, 1, 2'd0, 6'd0);
    checks++; if (bw.TAPOUT[5:0] !== 6'd0) $display("FAIL wrap_inc got %0d want 0", bw.TAPOUT[5:0]); else passes++;
    checks++; if (bw.FINEOVERFLOW !== 1'b1) $display("FAIL wrap_inc_ovf got %b want 1", bw.FINEOVERFLOW); else passes++;
    settle_w(n);
    cmd_w(1, 0, 0, 2'd0, 6'd10);
    checks++; if (bw.TAPOUT[5:0] !== 6'd10) $display("FAIL wrap_load10 got %0d want 10", bw.TAPOUT[5:0]); else passes++;
    checks++; if (bw.FINEOVERFLOW !== 1'b0) $display("FAIL wrap_load_ovf got %b want 0", bw.FINEOVERFLOW); else passes++;
    settle_w(n);
  endtask

  task automatic test_nonactive_switch();
    int n;
    cmd_s(0, 1, 0, 0, 0, 2'd1, 2'd0, 6'd20);
    checks++; if (bs.TAPOUT !== {6'd5, 6'd5, 6'd63, 6'd5}) $display("FAIL na_tapout got %h want %h", bs.TAPOUT, {6'd5, 6'd5, 6'd63, 6'd5}); else passes++;
    checks++; if (bs.BUSY !== 1'b0) $display("FAIL na_busy got %b want 0", bs.BUSY); else passes++;
    checks++; if (bs.FINEOVERFLOW !== 1'b0) $display("FAIL na_ovf_clr got %b want 0", bs.FINEOVERFLOW); else passes++;
    cmd_s(1, 0, 0, 0, 0, 2'd1, 2'd0, 6'd0);
    checks++; if (bs.ACTIVERANK !== 2'd1) $display("FAIL sw_rank got %0d want 1", bs.ACTIVERANK); else passes++;
    checks++; if (bs.TAPOUT !== {6'd5, 6'd5, 6'd5, 6'd20}) $display("FAIL sw_tapout got %h want %h", bs.TAPOUT, {6'd5, 6'd5, 6'd5, 6'd20}); else passes++;
    settle_s(n);
    checks++; if (n != 8) $display("FAIL sw_settle got %0d want 8", n); else passes++;
  endtask

  task automatic test_busy_reject();
    int n;
    cmd_s(0, 1, 0, 0, 0, 2'd1, 2'd2, 6'd30);
    cmd_s(0, 0, 1, 1, 0, 2'd1, 2'd2, 6'd0);
    checks++; if (bs.CMDERR !== 1'b1) $display("FAIL busy_cmderr got %b want 1", bs.CMDERR); else passes++;
    checks++; if (bs.TAPOUT[17:12] !== 6'd30) $display("FAIL busy_tap got %0d want 30", bs.TAPOUT[17:12]); else passes++;
    rd_q.push_back(6'd30);
    cmd_s(0, 0, 0, 0, 1, 2'd1, 2'd2, 6'd0);
    checks++; if (bs.CMDERR !== 1'b0) $display("FAIL busy_cmderr_pulse got %b want 0", bs.CMDERR); else passes++;
    checks++; if ({bs.BUSY, bs.READVALID} !== 2'b11) $display("FAIL busy_read got %b want 11", {bs.BUSY, bs.READVALID}); else passes++;
    settle_s(n);
  endtask

  task automatic test_read_before_write();
    int n;
    rd_q.push_back(6'd5);
    cmd_s(0, 1, 0, 0, 1, 2'd1, 2'd3, 6'd40);
    checks++; if (bs.TAPOUT[23:18] !== 6'd40) $display("FAIL rbw_tap got %0d want 40", bs.TAPOUT[23:18]); else passes++;
    settle_s(n);
    rd_q.push_back(6'd40);
    cmd_s(0, 0, 0, 0, 1, 2'd1, 2'd3, 6'd0);
  endtask

  task automatic test_priority_reset();
    cmd_s(1, 1, 1, 1, 0, 2'd2, 2'd0, 6'd50);
    checks++; if (bs.ACTIVERANK !== 2'd2) $display("FAIL prio_rank got %0d want 2", bs.ACTIVERANK); else passes++;
    checks++; if (bs.TAPOUT !== {4{6'd5}}) $display("FAIL prio_tapout got %h want %h", bs.TAPOUT, {4{6'd5}}); else passes++;
    checks++; if ({bs.BUSY, bs.CMDERR} !== 2'b10) $display("FAIL prio_flags got %b want 10", {bs.BUSY, bs.CMDERR}); else passes++;
    rd_q.push_back(6'd5);
    cmd_s(0, 0, 0, 0, 1, 2'd2, 2'd0, 6'd0);
    tick();
    RST = 1'b1; tick(); RST = 1'b0;
    checks++; if (bs.BUSY !== 1'b0) $display("FAIL rst_busy got %b want 0", bs.BUSY); else passes++;
    checks++; if (bs.TAPOUT !== {4{6'd5}}) $display("FAIL rst_tapout got %h want %h", bs.TAPOUT, {4{6'd5}}); else passes++;
    checks++; if (bs.ACTIVERANK !== 2'd0) $display("FAIL rst_rank got %0d want 0", bs.ACTIVERANK); else passes++;
    tick();
    checks++; if (bs.BUSY !== 1'b0) $display("FAIL rst_busy_after got %b want 0", bs.BUSY); else passes++;
    rd_q.push_back(6'd5);
    cmd_s(0, 0, 0, 0, 1, 2'd1, 2'd0, 6'd0);
    tick();
  endtask

  initial begin
    bs.RANKSWITCH = 0; bs.COUNTERLOADEN = 0; bs.FINEENABLE = 0; bs.FINEINC = 0;
    bs.COUNTERREADEN = 0; bs.RANKSEL = 0; bs.CHSEL = 0; bs.COUNTERLOADVAL = 0;
    bw.RANKSWITCH = 0; bw.COUNTERLOADEN = 0; bw.FINEENABLE = 0; bw.FINEINC = 0;
    bw.COUNTERREADEN = 0; bw.RANKSEL = 0; bw.CHSEL = 0; bw.COUNTERLOADVAL = 0;
    test_reset();
    test_saturate();
    test_wrap();
    test_nonactive_switch();
    test_busy_reject();
    test_read_before_write();
    test_priority_reset();
    checks++; if (rd_q.size() != 0) $display("FAIL rd_pending got %0d reads outstanding want 0", rd_q.size()); else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
